// File: rtl/leading_count_normalizer_if.sv
// Request/response bundle for leading_count_normalizer.
//   i_start       request strobe, taken in IDLE or DONE
//   i_src         operand, sampled on the accepting edge
//   i_count_ones  0 = CLZ, 1 = CLO, sampled with i_src
//   o_busy        operation in flight (SEARCH/FINAL)
//   o_done        one-cycle completion pulse
//   o_count       leading-bit count, 0..WORD_SIZE
//   o_norm        i_src << o_count, zero filled
interface leading_count_normalizer_if #(
  parameter int WORD_SIZE = 32
);
  localparam int L = $clog2(WORD_SIZE);

  logic                 i_start;
  logic [WORD_SIZE-1:0] i_src;
  logic                 i_count_ones;
  logic                 o_busy;
  logic                 o_done;
  logic [L:0]           o_count;
  logic [WORD_SIZE-1:0] o_norm;

  modport master (
    output i_start, i_src, i_count_ones,
    input  o_busy, o_done, o_count, o_norm
  );

  modport slave (
    input  i_start, i_src, i_count_ones,
    output o_busy, o_done, o_count, o_norm
  );
endinterface

// File: rtl/leading_count_normalizer.sv
// Multi-cycle count-leading-zeros/ones and left-normalize unit.
// Binary search over the operand, one halving step per clock, then a final
// single-bit step so that an all-match operand yields WORD_SIZE.
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   bus    leading_count_normalizer_if.slave (start/src/mode in,
//          busy/done/count/norm out)
module leading_count_normalizer #(
  parameter int WORD_SIZE = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  leading_count_normalizer_if.slave  bus
);
  localparam int L = $clog2(WORD_SIZE);
  localparam logic [L-1:0] STAGE_TOP = L'(L-1);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_FINAL, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic                 w_accept;
  logic [WORD_SIZE-1:0] r_work;
  logic [L:0]           r_cnt;
  logic [L-1:0]         r_stage;
  logic                 r_m;
  logic [L:0]           r_count;
  logic [WORD_SIZE-1:0] r_norm;

  // Window width for this stage and a mask selecting the top w bits.
  logic [L:0]           w_width;
  logic [WORD_SIZE-1:0] w_mask;
  logic                 w_match;

  assign w_width = (L+1)'(1) << r_stage;
  assign w_mask  = ~({WORD_SIZE{1'b1}} >> w_width);
  assign w_match = ((r_work ^ {WORD_SIZE{r_m}}) & w_mask) == '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.i_start) begin
        w_accept    = 1'b1;
        w_state_nxt = S_SEARCH;
      end
      S_SEARCH: if (r_stage == '0) w_state_nxt = S_FINAL;
      S_FINAL:  w_state_nxt = S_DONE;
      S_DONE: begin
        if (bus.i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SEARCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_work  <= '0;
      r_cnt   <= '0;
      r_stage <= '0;
      r_m     <= 1'b0;
      r_count <= '0;
      r_norm  <= '0;
    end else if (w_accept) begin
      r_work  <= bus.i_src;
      r_cnt   <= '0;
      r_stage <= STAGE_TOP;
      r_m     <= bus.i_count_ones;
    end else if (r_state == S_SEARCH) begin
      if (w_match) begin
        r_work <= r_work << w_width;
        r_cnt  <= r_cnt + w_width;
      end
      if (r_stage != '0) r_stage <= r_stage - L'(1);
    end else if (r_state == S_FINAL) begin
      // The search windows sum to WORD_SIZE-1; one more bit may still match.
      if (r_work[WORD_SIZE-1] == r_m) begin
        r_count <= r_cnt + (L+1)'(1);
        r_norm  <= r_work << 1;
      end else begin
        r_count <= r_cnt;
        r_norm  <= r_work;
      end
    end
  end

  assign bus.o_busy  = (r_state == S_SEARCH) || (r_state == S_FINAL);
  assign bus.o_done  = (r_state == S_DONE);
  assign bus.o_count = r_count;
  assign bus.o_norm  = r_norm;
endmodule
